// File: rtl/uart_tx_fifo_if.sv
// Producer and transmitter signals of the UART transmit FIFO.
// The FIFO takes the slave view; the surrounding logic takes the master view.
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow;
    logic                  tx_busy;
    logic [7:0]            tx_data;
    logic                  tx_wrsig;

    modport master (
        output wr_en, wr_data, tx_busy,
        input  full, empty, level, overflow, tx_data, tx_wrsig
    );

    modport slave (
        input  wr_en, wr_data, tx_busy,
        output full, empty, level, overflow, tx_data, tx_wrsig
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter, one start strobe per byte
// whenever the transmitter is idle; dropped pushes raise a sticky flag.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2   = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input logic           clk,
    input logic           rst,
    uart_tx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                state;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic [DEPTH_LOG2:0]   level_nxt;
    logic                  full;
    logic                  empty;
    logic                  overflow;
    logic [7:0]            tx_data;
    logic                  tx_wrsig;
    logic [CW-1:0]         cnt;
    logic                  push;
    logic                  pop;

    assign push = bus.wr_en && !full;
    assign pop  = (state == IDLE) && !empty && !bus.tx_busy;

    always_comb begin
        level_nxt = level;
        if (push && !pop)
            level_nxt = level + 1'b1;
        else if (pop && !push)
            level_nxt = level - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            // full is the pre-update flag, so a same-cycle pop never rescues the push
            if (bus.wr_en && full)
                overflow <= 1'b1;
            level <= level_nxt;
            full  <= (level_nxt == FULL_LVL);
            empty <= (level_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_data  <= 8'h00;
            tx_wrsig <= 1'b0;
            cnt      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        state    <= LOAD;
                        tx_data  <= mem[rd_ptr];
                        tx_wrsig <= 1'b1;
                    end
                end
                LOAD: begin
                    state    <= WAIT_BUSY;
                    tx_wrsig <= 1'b0;
                    cnt      <= '0;
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state <= WAIT_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        // no busy response: count the byte as sent, no retry
                        if (cnt == CW'(BUSY_TIMEOUT - 1))
                            state <= IDLE;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.level    = level;
    assign bus.overflow = overflow;
    assign bus.tx_data  = tx_data;
    assign bus.tx_wrsig = tx_wrsig;
endmodule
